// File: rtl/clk_div_gen.sv
// Runtime-programmable clock divider: registered divided clock plus rise/fall
// strobes. A new divisor is held pending and only takes effect at a period start.
module clk_div_gen #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 162
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             running,
  output logic [CNT_W-1:0] div_active
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_rise_q, tick_rise_d;
  logic             tick_fall_q, tick_fall_d;
  logic             running_q, running_d;
  logic [CNT_W-1:0] div_active_q, div_active_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_vld_q, pend_vld_d;

  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] load_val;
  logic             last;
  logic             start;

  assign half     = div_active_q - (div_active_q >> 1);
  assign cnt_inc  = cnt_q + ONE;
  assign last     = (cnt_q == div_active_q - ONE);
  assign load_val = (div_in < MIN_DIV) ? MIN_DIV : div_in;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clk_out_d    = clk_out_q;
    tick_rise_d  = 1'b0;
    tick_fall_d  = 1'b0;
    div_active_d = div_active_q;
    div_pend_d   = div_pend_q;
    pend_vld_d   = pend_vld_q;
    start        = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        start     = en;
      end
      RUN: begin
        if (last) begin
          if (en) begin
            start = 1'b1;
          end else begin
            state_d   = IDLE;
            cnt_d     = '0;
            clk_out_d = 1'b0;
          end
        end else begin
          cnt_d       = cnt_inc;
          clk_out_d   = (cnt_inc < half);
          tick_fall_d = (cnt_inc == half);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d     = RUN;
      cnt_d       = '0;
      clk_out_d   = 1'b1;
      tick_rise_d = 1'b1;
    end

    // Pending divisor switches only at a boundary; a same-cycle load waits one more.
    if ((state_q == IDLE || start) && pend_vld_q) begin
      div_active_d = div_pend_q;
      pend_vld_d   = 1'b0;
    end
    if (div_load) begin
      div_pend_d = load_val;
      pend_vld_d = 1'b1;
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      clk_out_q    <= 1'b0;
      tick_rise_q  <= 1'b0;
      tick_fall_q  <= 1'b0;
      running_q    <= 1'b0;
      div_active_q <= DEF_DIV;
      div_pend_q   <= DEF_DIV;
      pend_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clk_out_q    <= clk_out_d;
      tick_rise_q  <= tick_rise_d;
      tick_fall_q  <= tick_fall_d;
      running_q    <= running_d;
      div_active_q <= div_active_d;
      div_pend_q   <= div_pend_d;
      pend_vld_q   <= pend_vld_d;
    end
  end

  assign clk_out    = clk_out_q;
  assign tick_rise  = tick_rise_q;
  assign tick_fall  = tick_fall_q;
  assign running    = running_q;
  assign div_active = div_active_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: a per-cycle vector table followed by
// hand-written sequences for phase lengths, load timing, stop and reset.
module tb_clk_div_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div_in = '0;
  logic        div_load = 1'b0;
  logic        clk_out, tick_rise, tick_fall, running;
  logic [15:0] div_active;

  int checks = 0;
  int failures = 0;

  clk_div_gen #(.CNT_W(16), .DEFAULT_DIV(162)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .div_in     (div_in),
    .div_load   (div_load),
    .clk_out    (clk_out),
    .tick_rise  (tick_rise),
    .tick_fall  (tick_fall),
    .running    (running),
    .div_active (div_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        load;
    logic [15:0] din;
    logic        ck;
    logic        rs;
    logic        fl;
    logic        run;
    logic [15:0] dv;
  } vec_t;

  vec_t vecs[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    step();
    rst_n    = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_in   = '0;
    step();
    rst_n = 1'b1;
  endtask

  // Counts consecutive sampled cycles with clk_out at lvl, bounded.
  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (clk_out === lvl && n < 1000) begin
      n++;
      step();
    end
  endtask

  task automatic load_and_step(input logic [15:0] d);
    div_load = 1'b1;
    div_in   = d;
    step();
    div_load = 1'b0;
  endtask

  initial begin
    int n;
    bit stayed;

    //            en    ld    din     ck    rs    fl    run   dv
    vecs[0]  = '{1'b0, 1'b1, 16'd3,  1'b0, 1'b0, 1'b0, 1'b0, 16'd162};
    vecs[1]  = '{1'b0, 1'b1, 16'd10, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
    vecs[2]  = '{1'b1, 1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 1'b1, 16'd10};
    vecs[3]  = '{1'b1, 1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b1, 16'd10};
    vecs[4]  = '{1'b1, 1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b1, 16'd10};
    vecs[5]  = '{1'b1, 1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b1, 16'd10};
    vecs[6]  = '{1'b1, 1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b1, 16'd10};
    vecs[7]  = '{1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 1'b1, 1'b1, 16'd10};
    vecs[8]  = '{1'b1, 1'b1, 16'd1,  1'b0, 1'b0, 1'b0, 1'b1, 16'd10};
    vecs[9]  = '{1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b1, 16'd10};
    vecs[10] = '{1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b1, 16'd10};
    vecs[11] = '{1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b1, 16'd10};
    vecs[12] = '{1'b1, 1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[13] = '{1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 1'b1, 1'b1, 16'd2};
    vecs[14] = '{1'b1, 1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[15] = '{1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 1'b1, 1'b1, 16'd2};
    vecs[16] = '{1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0, 16'd2};

    do_reset();
    check("rst clk_out", clk_out, 0);
    check("rst tick_rise", tick_rise, 0);
    check("rst tick_fall", tick_fall, 0);
    check("rst running", running, 0);
    check("rst div_active", div_active, 162);

    for (int i = 0; i < 17; i++) begin
      en       = vecs[i].en;
      div_load = vecs[i].load;
      div_in   = vecs[i].din;
      step();
      check($sformatf("vec%0d clk_out", i), clk_out, vecs[i].ck);
      check($sformatf("vec%0d tick_rise", i), tick_rise, vecs[i].rs);
      check($sformatf("vec%0d tick_fall", i), tick_fall, vecs[i].fl);
      check($sformatf("vec%0d running", i), running, vecs[i].run);
      check($sformatf("vec%0d div_active", i), div_active, vecs[i].dv);
    end
    div_load = 1'b0;
    en = 1'b0;

    // Default divisor 162: 81 high, 81 low
    do_reset();
    en = 1'b1;
    step();
    check("def start clk_out", clk_out, 1);
    check("def start rise", tick_rise, 1);
    check("def div_active", div_active, 162);
    measure(1'b1, n);
    check("def high len", n, 81);
    check("def fall strobe", tick_fall, 1);
    measure(1'b0, n);
    check("def low len", n, 81);
    check("def second rise", tick_rise, 1);

    // Single load of 3: 2 high / 1 low
    do_reset();
    load_and_step(16'd3);
    en = 1'b1;
    step();
    check("d3 div_active", div_active, 3);
    measure(1'b1, n);
    check("d3 high len", n, 2);
    measure(1'b0, n);
    check("d3 low len", n, 1);
    check("d3 rise", tick_rise, 1);

    // Load 4 mid-period at D=10: current period finishes at 10
    do_reset();
    load_and_step(16'd10);
    en = 1'b1;
    step();
    repeat (5) step();
    load_and_step(16'd4);
    check("mid div still 10", div_active, 10);
    measure(1'b0, n);
    check("mid remaining low", n, 4);
    check("mid boundary rise", tick_rise, 1);
    check("mid new div", div_active, 4);
    measure(1'b1, n);
    check("mid d4 high", n, 2);
    measure(1'b0, n);
    check("mid d4 low", n, 2);

    // Load on the boundary edge: one more full D=10 period first
    do_reset();
    load_and_step(16'd10);
    en = 1'b1;
    step();
    repeat (9) step();
    load_and_step(16'd4);
    check("bnd rise", tick_rise, 1);
    check("bnd div still 10", div_active, 10);
    measure(1'b1, n);
    check("bnd high", n, 5);
    measure(1'b0, n);
    check("bnd low", n, 5);
    check("bnd next div", div_active, 4);
    measure(1'b1, n);
    check("bnd d4 high", n, 2);

    // div_in=0 clamps to 2
    do_reset();
    load_and_step(16'd0);
    en = 1'b1;
    step();
    check("clamp0 div", div_active, 2);
    check("clamp0 clk_out", clk_out, 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("clamp0 clk c%0d", i), clk_out, (i % 2 == 0));
      check($sformatf("clamp0 rise c%0d", i), tick_rise, (i % 2 == 0));
    end

    // en dropped at cnt=2: period completes, then idle
    do_reset();
    load_and_step(16'd10);
    en = 1'b1;
    step();
    repeat (2) step();
    en = 1'b0;
    n = 0;
    while (running === 1'b1 && n < 50) begin
      n++;
      step();
    end
    check("stop cycles", n, 8);
    stayed = 1'b1;
    repeat (5) begin
      if (clk_out !== 1'b0 || running !== 1'b0) stayed = 1'b0;
      step();
    end
    check("stop stays low", stayed, 1);

    // en re-asserted at cnt=7: no gap
    do_reset();
    load_and_step(16'd10);
    en = 1'b1;
    step();
    repeat (2) step();
    en = 1'b0;
    stayed = 1'b1;
    repeat (5) begin
      step();
      if (running !== 1'b1) stayed = 1'b0;
    end
    en = 1'b1;
    repeat (3) begin
      step();
      if (running !== 1'b1) stayed = 1'b0;
    end
    check("repulse running held", stayed, 1);
    check("repulse rise", tick_rise, 1);

    // Async reset in high phase drops clk_out and pending divisor
    do_reset();
    en = 1'b1;
    step();
    repeat (3) step();
    load_and_step(16'd10);
    check("pre-rst clk_out", clk_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst clk_out", clk_out, 0);
    check("async rst running", running, 0);
    check("async rst div", div_active, 162);
    step();
    rst_n = 1'b1;
    en = 1'b1;
    step();
    check("post-rst rise", tick_rise, 1);
    check("post-rst div", div_active, 162);
    repeat (162) step();
    check("post-rst period rise", tick_rise, 1);
    check("post-rst pend lost", div_active, 162);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
